axis_complex_xform: RTL
=======================

AXIS_COMPLEX_XFORM -- requirements
Module: axis_complex_xform

Interface
REQ-001 Parameter DATA_W, default 32: width of each complex component; tdata is 2*DATA_W.
REQ-002 Parameter FRAME_LEN, default 4096: nominal beats per frame, power of two, >= 2.
REQ-003 Parameter SATURATE, default 1: 1 = saturating negation, 0 = two's-complement wrap.
REQ-004 s00_axis_aclk  in  1  single clock for all logic.
REQ-005 s00_axis_areset  in  1  asynchronous, active-high reset.
REQ-006 s00_axis_tdata  in  2*DATA_W  {re[2W-1:W], im[W-1:0]}, signed two's complement.
REQ-007 s00_axis_tvalid / s00_axis_tlast  in  1 each; s00_axis_tready  out  1.
REQ-008 m00_axis_tdata  out  2*DATA_W, same packing; m00_axis_tvalid, m00_axis_tlast  out  1; m00_axis_tready  in  1.
REQ-009 mode_req  in  2  00 pass, 01 conjugate, 10 negate both, 11 multiply by j.
REQ-010 mute_req  in  1  zero output data for the frame.
REQ-011 err_clr  in  1  clears frame_err.
REQ-012 frame_err  out  1  sticky framing-mismatch flag.
REQ-013 frame_cnt  out  16  completed-frame counter, wraps 0xFFFF->0.

Function
REQ-014 Input beat accepted when s00_axis_tvalid && s00_axis_tready; output beat transferred when m00_axis_tvalid && m00_axis_tready.
REQ-015 Datapath: one output register plus a one-entry skid buffer; s00_axis_tready is a register output, low only while the skid entry is occupied.
REQ-016 Latency: an accepted beat appears on m00 the next cycle when the output register is empty or being drained.
REQ-017 Throughput: one beat/cycle sustained while m00_axis_tready is high; no beat lost or duplicated under any m00_axis_tready pattern.
REQ-018 m00_axis_tvalid stays asserted and m00 data/last stay stable until transfer.
REQ-019 Beat counter of log2(FRAME_LEN) bits, incremented on each accepted beat.
REQ-020 Frame end: accepted beat with s00_axis_tlast=1 or counter==FRAME_LEN-1; counter returns to 0.
REQ-021 frame_err set at a frame end where tlast and (counter==FRAME_LEN-1) disagree; counter still resets.
REQ-022 err_clr clears frame_err; if set and clear occur in the same cycle, set wins.
REQ-023 frame_cnt increments by 1 at every frame end.
REQ-024 Beat with counter==0 uses mode_req/mute_req sampled in its acceptance cycle; those values are latched as active_mode/active_mute and used for all remaining beats of the frame.
REQ-025 mode/mute changes mid-frame have no effect until the next frame's first beat.
REQ-026 Transform: 00 (re,im); 01 (re,-im); 10 (-re,-im); 11 (-im,re).
REQ-027 Negation of -2^(DATA_W-1): SATURATE=1 gives 2^(DATA_W-1)-1; SATURATE=0 gives -2^(DATA_W-1).
REQ-028 active_mute=1: m00_axis_tdata all zeros; tvalid/tlast timing unchanged.
REQ-029 m00_axis_tlast equals s00_axis_tlast of the same beat (passed through, not regenerated).

Reset
REQ-030 On reset assertion, immediately: m00_axis_tvalid=0, s00_axis_tready=0, skid empty, counter=0, frame_err=0, frame_cnt=0, active_mode=00, active_mute=0.
REQ-031 s00_axis_tready rises on the first clock edge after reset deassertion.
REQ-032 Reset mid-frame discards in-flight beats; the next accepted beat is counter 0.
REQ-033 m00_axis_tdata and m00_axis_tlast are don't-care while m00_axis_tvalid=0.

Verification
REQ-034 mode=01, DATA_W=32, in 0x00000005_00000003 -> out 0x00000005_FFFFFFFD, 1-cycle latency.
REQ-035 mode=11, in re=2, im=-7 -> out re=7, im=2; mode=10, SATURATE=1, in re=0x80000000 -> out re=0x7FFFFFFF.
REQ-036 Random m00_axis_tready (50%) with continuous input, 3 frames of 4096 -> output stream matches model bit-exact, frame_cnt=3, frame_err=0.
REQ-037 mode_req 00->01 at beat 100 of a frame -> beats 100..4095 unchanged; next frame conjugated from beat 0.
REQ-038 tlast at beat 10 of a frame -> frame_err=1, counter=0, frame_cnt+1; err_clr pulse -> frame_err=0; tlast absent at beat 4095 -> frame_err=1.
REQ-039 mute_req=1 asserted before frame start -> whole frame outputs 0 with tlast on beat 4095; reset at beat 2000 -> m00_axis_tvalid=0 immediately, next frame counted from 0.

Source files
------------

// File: rtl/axis_complex_xform.sv
// AXI4-Stream complex-sample transform (pass / conjugate / negate / multiply-by-j) with
// per-frame latched mode and mute, frame bookkeeping and a skid-buffered output stage.
module axis_complex_xform #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 4096,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                s00_axis_aclk,
  input  logic                s00_axis_areset,
  input  logic [2*DATA_W-1:0] s00_axis_tdata,
  input  logic                s00_axis_tvalid,
  input  logic                s00_axis_tlast,
  output logic                s00_axis_tready,
  output logic [2*DATA_W-1:0] m00_axis_tdata,
  output logic                m00_axis_tvalid,
  output logic                m00_axis_tlast,
  input  logic                m00_axis_tready,
  input  logic [1:0]          mode_req,
  input  logic                mute_req,
  input  logic                err_clr,
  output logic                frame_err,
  output logic [15:0]         frame_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [DATA_W-1:0] S_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] S_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_CONJ = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_MULJ = 2'b11;

  // The most negative value has no positive counterpart; clamp or wrap.
  function automatic logic [DATA_W-1:0] neg_fn(input logic [DATA_W-1:0] x);
    if (x == S_MIN) begin
      neg_fn = (SATURATE != 1'b0) ? S_MAX : S_MIN;
    end else begin
      neg_fn = (~x) + {{(DATA_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic                r_s_ready;
  logic                r_o_valid;
  logic [2*DATA_W-1:0] r_o_data;
  logic                r_o_last;
  logic                r_sk_valid;
  logic [2*DATA_W-1:0] r_sk_data;
  logic                r_sk_last;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_mode;
  logic                r_mute;
  logic                r_frame_err;
  logic [15:0]         r_frame_cnt;

  logic                w_acc;
  logic                w_o_free;
  logic                w_drain;
  logic                w_cnt_last;
  logic                w_end;
  logic                w_mismatch;
  logic                w_first;
  logic [1:0]          w_mode;
  logic                w_mute;
  logic [DATA_W-1:0]   w_re;
  logic [DATA_W-1:0]   w_im;
  logic [DATA_W-1:0]   w_xre;
  logic [DATA_W-1:0]   w_xim;
  logic [2*DATA_W-1:0] w_beat;

  assign w_acc      = s00_axis_tvalid && r_s_ready;
  assign w_drain    = r_o_valid && m00_axis_tready;
  assign w_o_free   = !r_o_valid || m00_axis_tready;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_end      = w_acc && (s00_axis_tlast || w_cnt_last);
  assign w_mismatch = w_end && (s00_axis_tlast != w_cnt_last);

  // Transform the incoming beat; the first beat of a frame uses the live request.
  always_comb begin
    w_re    = s00_axis_tdata[2*DATA_W-1:DATA_W];
    w_im    = s00_axis_tdata[DATA_W-1:0];
    w_first = (r_cnt == {CNT_W{1'b0}});
    w_mode  = w_first ? mode_req : r_mode;
    w_mute  = w_first ? mute_req : r_mute;
    case (w_mode)
      MODE_PASS: begin w_xre = w_re;         w_xim = w_im;         end
      MODE_CONJ: begin w_xre = w_re;         w_xim = neg_fn(w_im); end
      MODE_NEG:  begin w_xre = neg_fn(w_re); w_xim = neg_fn(w_im); end
      MODE_MULJ: begin w_xre = neg_fn(w_im); w_xim = w_re;         end
      default:   begin w_xre = w_re;         w_xim = w_im;         end
    endcase
    if (w_mute) begin
      w_beat = {(2*DATA_W){1'b0}};
    end else begin
      w_beat = {w_xre, w_xim};
    end
  end

  // Output register plus one-entry skid; tready drops only while the skid holds a beat.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      r_s_ready  <= 1'b0;
      r_o_valid  <= 1'b0;
      r_o_data   <= {(2*DATA_W){1'b0}};
      r_o_last   <= 1'b0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= {(2*DATA_W){1'b0}};
      r_sk_last  <= 1'b0;
    end else if (r_sk_valid) begin
      if (w_o_free) begin
        r_o_valid  <= 1'b1;
        r_o_data   <= r_sk_data;
        r_o_last   <= r_sk_last;
        r_sk_valid <= 1'b0;
        r_s_ready  <= 1'b1;
      end else begin
        r_s_ready  <= 1'b0;
      end
    end else if (w_acc) begin
      if (w_o_free) begin
        r_o_valid  <= 1'b1;
        r_o_data   <= w_beat;
        r_o_last   <= s00_axis_tlast;
        r_s_ready  <= 1'b1;
      end else begin
        r_sk_valid <= 1'b1;
        r_sk_data  <= w_beat;
        r_sk_last  <= s00_axis_tlast;
        r_s_ready  <= 1'b0;
      end
    end else begin
      if (w_drain) begin
        r_o_valid <= 1'b0;
      end else begin
        r_o_valid <= r_o_valid;
      end
      r_s_ready <= 1'b1;
    end
  end

  // Beat counter, per-frame mode/mute latch and frame status.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_mode      <= 2'b00;
      r_mute      <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      if (w_acc && w_first) begin
        r_mode <= mode_req;
        r_mute <= mute_req;
      end else begin
        r_mode <= r_mode;
        r_mute <= r_mute;
      end
      if (w_end) begin
        r_cnt       <= {CNT_W{1'b0}};
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else if (w_acc) begin
        r_cnt       <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt       <= r_cnt;
      end
      if (w_mismatch) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end else begin
        r_frame_err <= r_frame_err;
      end
    end
  end

  assign s00_axis_tready = r_s_ready;
  assign m00_axis_tvalid = r_o_valid;
  assign m00_axis_tdata  = r_o_data;
  assign m00_axis_tlast  = r_o_last;
  assign frame_err       = r_frame_err;
  assign frame_cnt       = r_frame_cnt;

endmodule
